// File: rtl/mandel_feeder_pkg.sv
// Shared definitions for the Mandelbrot pixel feeder.
// Holds the Q4.12 fixed-point format constants, the saturation limits,
// the coordinate width and the feeder state encoding.
package mandel_feeder_pkg;

  localparam int unsigned FRAC_BITS = 12;
  localparam int unsigned Q_W       = 4 + FRAC_BITS;
  localparam int unsigned COORD_W   = 10;

  localparam logic [Q_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [Q_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mandel_feeder_sat_add16.sv
// Saturating Q4.12 accumulator step.
// Ports:
//   a   - signed Q4.12 running value
//   b   - unsigned Q4.12 increment (pixel pitch)
//   sub - 1: a - b, 0: a + b
//   sum - signed Q4.12 result, clamped to SAT_POS / SAT_NEG
module sat_add16
  import mandel_feeder_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  input  logic           sub,
  output logic [Q_W-1:0] sum
);

  // b is an unsigned magnitude, so two guard bits keep a +/- b exact
  // for the whole pitch range before clamping.
  localparam logic signed [Q_W+1:0] HI = $signed({2'b00, SAT_POS});
  localparam logic signed [Q_W+1:0] LO = $signed({2'b11, SAT_NEG});

  logic signed [Q_W+1:0] full;

  always_comb begin
    if (sub) begin
      full = $signed({{2{a[Q_W-1]}}, a}) - $signed({2'b00, b});
    end else begin
      full = $signed({{2{a[Q_W-1]}}, a}) + $signed({2'b00, b});
    end
    sum = full[Q_W-1:0];
    if (full > HI) begin
      sum = SAT_POS;
    end else if (full < LO) begin
      sum = SAT_NEG;
    end
  end

endmodule

// File: rtl/mandel_feeder.sv
// Mandelbrot frame scanner: walks a width x height pixel grid and issues one
// pixel constant (c1 = real, c2 = imaginary) per clock into the first
// iteration stage, with the seed z, divergence tag and stage index fixed at 0.
// Ports:
//   Clk, Reset          - clock, synchronous active-high reset
//   start               - begin a frame (accepted in IDLE only)
//   stall               - freezes all state and outputs
//   x0, y0, step        - Q4.12 origin and pitch, latched at start
//   width, height       - frame size, latched at start
//   x, y, div, stage    - constant 0
//   c1, c2, px, py      - current slot's constant and pixel address
//   no_op               - 1 = bubble slot
//   busy, done          - scanning / one-cycle end-of-frame pulse
module mandel_feeder
  import mandel_feeder_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               stall,
  input  logic [Q_W-1:0]     x0,
  input  logic [Q_W-1:0]     y0,
  input  logic [Q_W-1:0]     step,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic [Q_W-1:0]     x,
  output logic [Q_W-1:0]     y,
  output logic [Q_W-1:0]     c1,
  output logic [Q_W-1:0]     c2,
  output logic [7:0]         div,
  output logic               no_op,
  output logic [6:0]         stage,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               busy,
  output logic               done
);

  state_t               state, state_n;
  logic [Q_W-1:0]       x0_q, step_q, x0_n, step_n;
  logic [COORD_W-1:0]   w_q, h_q, w_n, h_n, px_n, py_n;
  logic [Q_W-1:0]       c1_n, c2_n, c1_inc, c2_dec;
  logic                 no_op_n, busy_n, done_n;

  assign x     = '0;
  assign y     = '0;
  assign div   = '0;
  assign stage = '0;

  sat_add16 u_c1_acc (.a(c1), .b(step_q), .sub(1'b0), .sum(c1_inc));
  sat_add16 u_c2_acc (.a(c2), .b(step_q), .sub(1'b1), .sum(c2_dec));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      x0_q   <= '0;
      step_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
      px     <= '0;
      py     <= '0;
      c1     <= '0;
      c2     <= '0;
      no_op  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      x0_q   <= x0_n;
      step_q <= step_n;
      w_q    <= w_n;
      h_q    <= h_n;
      px     <= px_n;
      py     <= py_n;
      c1     <= c1_n;
      c2     <= c2_n;
      no_op  <= no_op_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Outputs are the registered image of the slot; holding every next value
  // at its current value is what makes stall re-present the slot.
  always_comb begin
    state_n = state;
    x0_n    = x0_q;
    step_n  = step_q;
    w_n     = w_q;
    h_n     = h_q;
    px_n    = px;
    py_n    = py;
    c1_n    = c1;
    c2_n    = c2;
    no_op_n = no_op;
    busy_n  = busy;
    done_n  = done;
    if (!stall) begin
      case (state)
        IDLE: begin
          no_op_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b0;
          if (start) begin
            if (width == '0 || height == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = RUN;
              x0_n    = x0;
              step_n  = step;
              w_n     = width;
              h_n     = height;
              px_n    = '0;
              py_n    = '0;
              c1_n    = x0;
              c2_n    = y0;
              no_op_n = 1'b0;
              busy_n  = 1'b1;
            end
          end
        end
        RUN: begin
          no_op_n = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          if (px == w_q - 10'd1) begin
            if (py == h_q - 10'd1) begin
              state_n = DONE;
              no_op_n = 1'b1;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              px_n = '0;
              py_n = py + 10'd1;
              c1_n = x0_q;
              c2_n = c2_dec;
            end
          end else begin
            px_n = px + 10'd1;
            c1_n = c1_inc;
          end
        end
        DONE: begin
          state_n = IDLE;
          no_op_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          no_op_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_feeder.sv
module tb_mandel_feeder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [15:0] x0 = '0, y0 = '0, step = '0;
  logic [9:0]  width = '0, height = '0;
  logic [15:0] x, y, c1, c2;
  logic [7:0]  div;
  logic        no_op, busy, done;
  logic [6:0]  stage;
  logic [9:0]  px, py;

  always #5 Clk = ~Clk;

  mandel_feeder dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
    .x0(x0), .y0(y0), .step(step), .width(width), .height(height),
    .x(x), .y(y), .c1(c1), .c2(c2), .div(div), .no_op(no_op),
    .stage(stage), .px(px), .py(py), .busy(busy), .done(done)
  );

  typedef struct {
    bit no_op, busy, done;
    int px, py, c1, c2;
  } slot_t;

  slot_t pend[$];
  slot_t cur;
  slot_t seen[$];
  int    checks = 0, errors = 0;
  bit    chk_en = 1'b0;

  int exp_c1_a[6] = '{'hE000, 'hE800, 'hF000, 'hE000, 'hE800, 'hF000};
  int exp_c2_a[6] = '{'h1000, 'h1000, 'h1000, 'h0800, 'h0800, 'h0800};
  int exp_px_a[6] = '{0, 1, 2, 0, 1, 2};
  int exp_py_a[6] = '{0, 0, 0, 1, 1, 1};
  int exp_c1_b[9] = '{'hE000, 'hE800, 'hE800, 'hE800, 'hE800, 'hF000, 'hE000, 'hE800, 'hF000};
  int exp_c1_c[3] = '{'h7C00, 'h7FFF, 'h7FFF};
  int exp_c1_d[8] = '{'h1000, 'h1100, 'h1200, 'h1300, 'h1000, 'h1100, 'h1200, 'h1300};

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  function automatic slot_t idle_slot();
    slot_t s;
    s = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    return s;
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Whole frame as a list of slots: raster order, then the done slot.
  function automatic void gen_frame(input int fx0, input int fy0, input int fst,
                                    input int fw, input int fh);
    int cc1, cc2;
    slot_t s;
    cc2 = fy0;
    for (int r = 0; r < fh && fw > 0; r++) begin
      cc1 = fx0;
      for (int col = 0; col < fw; col++) begin
        s = '{1'b0, 1'b1, 1'b0, col, r, cc1, cc2};
        pend.push_back(s);
        cc1 = sat(cc1 + fst);
      end
      cc2 = sat(cc2 - fst);
    end
    s = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0};
    pend.push_back(s);
  endfunction

  initial cur = idle_slot();

  // Reference: a frame is a stream of slots; stall holds the current one,
  // a start is accepted only when nothing is queued and no done is showing.
  always @(posedge Clk) begin
    if (Reset) begin
      pend.delete();
      cur = idle_slot();
    end else if (!stall) begin
      if (pend.size() != 0) begin
        cur = pend.pop_front();
      end else if (!cur.done && start) begin
        gen_frame(int'($signed(x0)), int'($signed(y0)), int'(step),
                  int'(width), int'(height));
        cur = pend.pop_front();
      end else begin
        cur = idle_slot();
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("no_op", int'(no_op), int'(cur.no_op));
      check("busy", int'(busy), int'(cur.busy));
      check("done", int'(done), int'(cur.done));
      check("xy_div_stage_zero", int'(x | y | {8'd0, div} | {9'd0, stage}), 0);
      if (!cur.no_op) begin
        check("px", int'(px), cur.px);
        check("py", int'(py), cur.py);
        check("c1", int'($signed(c1)), cur.c1);
        check("c2", int'($signed(c2)), cur.c2);
      end
      if (!no_op) seen.push_back('{1'b0, 1'b1, 1'b0, int'(px), int'(py), int'(c1), int'(c2)});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic launch(input logic [15:0] ax0, input logic [15:0] ay0, input logic [15:0] ast,
                        input logic [9:0] aw, input logic [9:0] ah);
    x0 = ax0; y0 = ay0; step = ast; width = aw; height = ah;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    bit got;
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    check("done_seen_in_budget", int'(got), 1);
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    tick(); tick();
    check("rst_no_op", int'(no_op), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_px_py", int'(px) + int'(py), 0);
    check("rst_c1_c2", int'(c1 | c2), 0);
    Reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // 3x2 reference frame
    seen.delete();
    launch(16'hE000, 16'h1000, 16'h0800, 10'd3, 10'd2);
    wait_done(50);
    check("f1_live_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      check("f1_c1", seen[i].c1, exp_c1_a[i]);
      check("f1_c2", seen[i].c2, exp_c2_a[i]);
      check("f1_px", seen[i].px, exp_px_a[i]);
      check("f1_py", seen[i].py, exp_py_a[i]);
    end

    // same frame, stall held three edges on the second pixel
    seen.delete();
    launch(16'hE000, 16'h1000, 16'h0800, 10'd3, 10'd2);
    tick();
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    wait_done(50);
    check("f2_slot_cycles", seen.size(), 9);
    for (int i = 0; i < 9 && i < seen.size(); i++) check("f2_c1", seen[i].c1, exp_c1_b[i]);

    // saturation on the column accumulator
    seen.delete();
    launch(16'h7C00, 16'h0000, 16'h0800, 10'd3, 10'd1);
    wait_done(50);
    check("f3_live_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) check("f3_c1_sat", seen[i].c1, exp_c1_c[i]);

    // empty frame
    seen.delete();
    launch(16'h0000, 16'h0000, 16'h0100, 10'd0, 10'd5);
    check("f4_done_next", int'(done), 1);
    check("f4_bubble", int'(no_op), 1);
    tick();
    check("f4_done_one_cycle", int'(done), 0);
    check("f4_no_live", seen.size(), 0);

    // reset during the 4th pixel of a 4x4 frame
    launch(16'h0000, 16'h0000, 16'h0100, 10'd4, 10'd4);
    tick(); tick(); tick();
    check("f5_fourth_px", int'(px), 3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("f5_rst_no_op", int'(no_op), 1);
    check("f5_rst_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      check("f5_no_done", int'(done), 0);
      tick();
    end
    seen.delete();
    launch(16'h0100, 16'h0200, 16'h0040, 10'd2, 10'd2);
    wait_done(50);
    check("f5_restart_count", seen.size(), 4);
    if (seen.size() > 0) check("f5_restart_origin", seen[0].px + seen[0].py, 0);

    // start mid-frame ignored
    seen.delete();
    launch(16'h1000, 16'h0000, 16'h0100, 10'd4, 10'd2);
    tick();
    x0 = 16'h3000; width = 10'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50);
    check("f6_live_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) check("f6_c1", seen[i].c1, exp_c1_d[i]);

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      tick();
      Reset  = ($urandom_range(0, 299) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      start  = ($urandom_range(0, 5) == 0);
      x0     = 16'($urandom);
      y0     = 16'($urandom);
      step   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1000));
      width  = 10'($urandom_range(0, 6));
      height = 10'($urandom_range(0, 5));
    end
    Reset = 1'b0; stall = 1'b0; start = 1'b0;
    for (int n = 0; n < 60; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
